// File: rtl/mem_ctrl_pkg.sv
// Shared core package: memory-controller FSM states, latency limit and the ALU op encoding.
package mem_ctrl_pkg;

  localparam int DATA_W      = 32;
  localparam int CNT_W       = 3;
  localparam int MAX_LATENCY = 7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DONE
  } mem_ctrl_state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_t;

  function automatic logic misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-to-SRAM bus seen by mem_ctrl; slave is the controller view, master the core/SRAM side.
interface mem_ctrl_if #(
  parameter int SRAM_AW = 14
);
  import mem_ctrl_pkg::*;

  logic [DATA_W-1:0]  core_addr;
  logic [DATA_W-1:0]  core_wdata;
  logic               core_read;
  logic               core_write;
  logic [DATA_W-1:0]  core_rdata;
  logic               core_resp;
  logic               core_err;
  logic               sram_en;
  logic               sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [DATA_W-1:0]  sram_wdata;
  logic [DATA_W-1:0]  sram_rdata;

  modport slave (
    input  core_addr, core_wdata, core_read, core_write, sram_rdata,
    output core_rdata, core_resp, core_err, sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output core_addr, core_wdata, core_read, core_write, sram_rdata,
    input  core_rdata, core_resp, core_err, sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/mem_ctrl.sv
// Single-port SRAM controller for the multicycle core; one core_resp pulse per access.
// Optional MEM_CTRL_ALIGN_CHECK_EN turns byte-misaligned requests into error responses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int SRAM_AW = 14,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  mem_ctrl_state_t    state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               we_q, we_d;
  logic               err_q, err_d;

  // Upper bits alias and the byte offset is dropped from the word address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.core_addr[DATA_W-1:SRAM_AW+2], bus.core_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.core_read || bus.core_write) begin
          addr_d  = bus.core_addr[SRAM_AW+1:2];
          wdata_d = bus.core_wdata;
          we_d    = bus.core_write;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
          err_d   = (bus.core_read && bus.core_write) || misaligned(bus.core_addr[1:0]);
`else
          err_d   = bus.core_read && bus.core_write;
`endif
          state_d = err_d ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_W'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Count 1 lines up with the cycle the SRAM presents the read word.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = bus.sram_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Outputs come only from registers or state decode, never from core inputs.
  assign bus.sram_en    = (state_q == ISSUE);
  assign bus.sram_we    = (state_q == ISSUE) && we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.core_resp  = (state_q == RESP);
  assign bus.core_err   = (state_q == RESP) && err_q;
  assign bus.core_rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: three instances (LATENCY 2, 1, 7) share one directed stimulus stream.
module tb_mem_ctrl;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd, wr;
  logic [31:0] addr, wdata;
  int          cyc = 0;

  logic [2:0]  en_w, we_w, resp_w, err_w;
  logic [13:0] saddr_w  [3];
  logic [31:0] swdata_w [3];
  logic [31:0] crdata_w [3];

  resp_t rq [3][$];
  acc_t  aq [3][$];

  int n_vec = 0;
  int n_bad = 0;
  int chk_seq = 0;
  int chk_seen = 0;
  int chk_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : gen_dut
    localparam int L = (k == 0) ? 2 : (k == 1) ? 1 : 7;

    mem_ctrl_if #(.SRAM_AW(14)) bus ();

    mem_ctrl #(.SRAM_AW(14), .LATENCY(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    logic [31:0] mem  [16384];
    logic [31:0] pipe [8];

    assign bus.core_addr  = addr;
    assign bus.core_wdata = wdata;
    assign bus.core_read  = rd[k];
    assign bus.core_write = wr[k];
    assign bus.sram_rdata = pipe[L-1];

    always @(posedge clk) begin
      if (bus.sram_en) begin
        if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
        pipe[0] <= mem[bus.sram_addr];
      end
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    assign en_w[k]     = bus.sram_en;
    assign we_w[k]     = bus.sram_we;
    assign resp_w[k]   = bus.core_resp;
    assign err_w[k]    = bus.core_err;
    assign saddr_w[k]  = bus.sram_addr;
    assign swdata_w[k] = bus.sram_wdata;
    assign crdata_w[k] = bus.core_rdata;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 7;
  endfunction

  task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %h, want %h", n, k, act, exp);
    end
  endtask

  resp_t p;
  acc_t  a;

  // Monitor: pops the scoreboard whenever a DUT presents an SRAM strobe or a response.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (en_w[k] === 1'b1) begin
        if (aq[k].size() == 0) chk("unexpected_sram_en", k, 32'd1, 32'd0);
        else begin
          a = aq[k].pop_front();
          chk("sram_en_cycle", k, 32'(cyc), 32'(a.cyc));
          chk("sram_we", k, 32'(we_w[k]), 32'(a.we));
          chk("sram_addr", k, 32'(saddr_w[k]), 32'(a.addr));
          if (a.we) chk("sram_wdata", k, swdata_w[k], a.wdata);
        end
      end
      if (resp_w[k] === 1'b1) begin
        if (rq[k].size() == 0) chk("unexpected_resp", k, 32'd1, 32'd0);
        else begin
          p = rq[k].pop_front();
          chk("resp_cycle", k, 32'(cyc), 32'(p.cyc));
          chk("core_err", k, 32'(err_w[k]), 32'(p.err));
          chk("core_rdata", k, crdata_w[k], p.rdata);
        end
      end
    end
    if (chk_seq != chk_seen) begin
      for (int k = 0; k < 3; k++) begin
        if (chk_mode == 1) begin
          chk("rst_core_resp", k, 32'(resp_w[k]), 32'd0);
          chk("rst_core_err", k, 32'(err_w[k]), 32'd0);
          chk("rst_core_rdata", k, crdata_w[k], 32'd0);
          chk("rst_sram_en", k, 32'(en_w[k]), 32'd0);
          chk("rst_sram_we", k, 32'(we_w[k]), 32'd0);
          chk("rst_sram_addr", k, 32'(saddr_w[k]), 32'd0);
          chk("rst_sram_wdata", k, swdata_w[k], 32'd0);
        end else begin
          chk("resp_queue_drained", k, 32'(rq[k].size()), 32'd0);
          chk("sram_queue_drained", k, 32'(aq[k].size()), 32'd0);
        end
      end
      chk_seen = chk_seq;
    end
  end

  // Issues one request to all instances and plays the core: hold until resp, then through DONE.
  task automatic req(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d,
                     input logic e, input logic [31:0] xr);
    int    t0;
    int    dcnt [3];
    resp_t ep;
    acc_t  ea;
    @(negedge clk);
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      ep.cyc   = e ? t0 + 1 : (r ? t0 + 2 + lat_of(k) : t0 + 2);
      ep.err   = e;
      ep.rdata = xr;
      rq[k].push_back(ep);
      if (!e) begin
        ea.cyc   = t0 + 1;
        ea.we    = w;
        ea.addr  = ad[15:2];
        ea.wdata = d;
        aq[k].push_back(ea);
      end
      dcnt[k] = 0;
    end
    addr  = ad;
    wdata = d;
    rd    = {3{r}};
    wr    = {3{w}};
    for (int i = 0; i < 40 && (rd | wr) != 3'b000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (dcnt[k] != 0) begin
          dcnt[k]--;
          if (dcnt[k] == 0) begin
            rd[k] = 1'b0;
            wr[k] = 1'b0;
          end
        end else if (resp_w[k] === 1'b1 && (rd[k] | wr[k])) begin
          dcnt[k] = 2;
        end
      end
    end
    rd = 3'b000;
    wr = 3'b000;
  endtask

  initial begin
    acc_t ea;
    int   t0;
    rst   = 1'b1;
    rd    = 3'b000;
    wr    = 3'b000;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_mode = 1;
    chk_seq++;
    repeat (2) @(negedge clk);

    req(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000);
    req(1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 32'hDEAD_BEEF);
    req(1'b0, 1'b1, 32'h0000_0004, 32'h0123_4567, 1'b0, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0123_4567);
    req(1'b1, 1'b0, 32'h0001_0004, 32'h0,         1'b0, 32'h0123_4567);
    req(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b0, 32'h0123_4567);
    req(1'b1, 1'b0, 32'h0000_FFFC, 32'h0,         1'b0, 32'hA5A5_A5A5);
    req(1'b1, 1'b1, 32'h0000_1000, 32'h1111_1111, 1'b1, 32'hA5A5_A5A5);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    req(1'b1, 1'b0, 32'h0000_1002, 32'h0,         1'b1, 32'hA5A5_A5A5);
`else
    req(1'b1, 1'b0, 32'h0000_1002, 32'h0,         1'b0, 32'hDEAD_BEEF);
`endif

    // Reset while every instance sits in WAIT: strobe seen, response abandoned.
    @(negedge clk);
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      ea.cyc   = t0 + 1;
      ea.we    = 1'b0;
      ea.addr  = 14'h0400;
      ea.wdata = 32'h0;
      aq[k].push_back(ea);
    end
    addr = 32'h0000_1000;
    rd   = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd  = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    chk_mode = 1;
    chk_seq++;
    repeat (10) @(negedge clk);

    req(1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 32'hDEAD_BEEF);
    req(1'b0, 1'b1, 32'h0000_2000, 32'h5555_AAAA, 1'b0, 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);

    chk_mode = 2;
    chk_seq++;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller sitting directly downstream of the multicycle core's memory port. It accepts the core's level-held `mem_read`/`mem_write` requests and services them from a single-port synchronous SRAM with a parameterised read latency. It returns one `core_resp` pulse per access together with registered read data. Error cases (simultaneous read/write, optionally misaligned address) complete without touching the SRAM.

## Interface
- `SRAM_AW`, 14: SRAM word-address width; the SRAM holds 2^SRAM_AW 32-bit words.
- `LATENCY`, 2: SRAM read latency in cycles, legal range 1..7.

- `clk`  in  1  core clock.
- `rst`  in  1  reset: synchronous to `clk`, active-high.
- `core_addr`  in  32  byte address from the core (its `mem_addr`).
- `core_wdata`  in  32  write data (its `mem_wdata`).
- `core_read`  in  1  read request, held high until `core_resp`.
- `core_write`  in  1  write request, held high until `core_resp`.
- `core_rdata`  out  32  registered read data; valid while `core_resp`=1.
- `core_resp`  out  1  one-cycle completion pulse.
- `core_err`  out  1  error flag; qualified by `core_resp`.
- `sram_en`  out  1  SRAM access strobe.
- `sram_we`  out  1  SRAM write enable; qualified by `sram_en`.
- `sram_addr`  out  SRAM_AW  word address, `core_addr[SRAM_AW+1:2]`.
- `sram_wdata`  out  32  write data.
- `sram_rdata`  in  32  read data, valid LATENCY cycles after the `sram_en` cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, DONE.
- IDLE
  - Samples the requests each cycle.
  - On `core_read` or `core_write`: latch address, write data and request type.
  - If both requests are high, or the alignment check fails (see Configuration): set the error bit and go to RESP.
  - Otherwise go to ISSUE.
- ISSUE
  - Drives `sram_en`=1, `sram_we`=write, `sram_addr`, `sram_wdata` for exactly one cycle.
  - A write goes to RESP.
  - A read loads the latency counter with LATENCY and goes to WAIT.
- WAIT
  - Decrements the 3-bit counter each cycle.
  - On the cycle the counter reaches 1, captures `sram_rdata` into the `core_rdata` register and goes to RESP.
- RESP
  - `core_resp`=1 for one cycle.
  - `core_err` equals the latched error bit.
  - Next state is DONE.
- DONE
  - One turnaround cycle in which requests are ignored, because the core's request may still be high.
  - Always returns to IDLE.
- Address handling: upper address bits above `SRAM_AW+1` are ignored, so accesses alias. `core_addr[1:0]` is dropped from `sram_addr`.
- `core_rdata` holds its last captured value; it is only updated by reads.
- Error accesses never assert `sram_en`.

## Timing
- Reset values: state IDLE; `core_resp`=0, `core_err`=0, `core_rdata`=0, `sram_en`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0.
- All outputs are registered or decoded from state only; there are no combinational paths from core inputs to outputs.
- Request seen in IDLE at cycle T0:
  - `sram_en` at T1.
  - Write: `core_resp` at T2.
  - Read: `core_resp` at T2+LATENCY.
  - Error: `core_resp` at T1.
- Minimum request-to-request spacing is resp cycle + DONE cycle. A new request is sampled no earlier than 2 cycles after `core_resp`.
- Requests deasserted mid-access are ignored; the access completes and still responds.
- `rst` asserted in any state: IDLE on the next edge. Any pending access is abandoned with no `core_resp`, and `sram_en` drops immediately.

## Configuration
- `MEM_CTRL_ALIGN_CHECK_EN` defined:
  - A request with `core_addr[1:0]`≠0 is an error.
  - It responds at T1 with `core_err`=1 and no SRAM access.
- Undefined:
  - No alignment check; `core_addr[1:0]` is silently ignored.
  - `core_err` is raised only for simultaneous read/write.

## Structure
- `mem_ctrl_state_t` (IDLE/ISSUE/WAIT/RESP/DONE) and the latency limit constant go in the shared core package alongside `alu_op_t`.
- No sub-module is needed.
- The FSM, latency counter and output registers live in one module.
- The SRAM itself is outside this block (bench model or macro).

## Test plan
- LATENCY=2, write 0xDEADBEEF to 0x1000 -> `sram_en`/`sram_we`=1 with `sram_addr`=0x400 at T1, `core_resp`=1 and `core_err`=0 at T2.
- Read 0x1000 after that write -> `core_rdata`=0xDEADBEEF with `core_resp` at T4; `sram_we`=0.
- LATENCY=1 and LATENCY=7 reads -> `core_resp` at T3 and T9 respectively.
- `core_read`=`core_write`=1 -> `core_resp`=`core_err`=1 at T1, `sram_en` never asserted.
- With `MEM_CTRL_ALIGN_CHECK_EN`, read 0x1002 -> error response at T1. Without it -> normal read of word 0x400 at T4.
- Assert `rst` during WAIT -> no `core_resp`. The next read after reset completes normally, and the request held through the DONE cycle is not double-serviced.
